pipeline_ctrl: RTL and testbench

- Central stall/flush sequencer for the 5-stage rv32i pipeline.
- Drives the per-stage `load` enables of the IF/ID, ID/EX, EX/MEM and MEM/WB registers and the PC register.
- Handshakes with the instruction and data memory ports and holds the whole pipeline until every outstanding access has responded.
- Inserts a bubble on load-use hazards and kills wrong-path instructions on an EX-stage redirect.

---
 rtl/pipeline_ctrl.sv | 134 +++++++++++++
 tb/tb_pipeline_ctrl.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the 5-stage rv32i pipeline: memory handshakes, load-use bubbles, redirect kills.
// Optional performance counters are built only when PIPE_PERF_EN is defined.
module pipeline_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             imem_resp,
  input  logic             dmem_resp,
  input  logic             ex_mem_read,
  input  logic             ex_mem_write,
  input  logic             id_ex_mem_read,
  input  logic [4:0]       id_ex_rd,
  input  logic [4:0]       if_id_rs1,
  input  logic [4:0]       if_id_rs2,
  input  logic             if_id_use_rs1,
  input  logic             if_id_use_rs2,
  input  logic             br_taken,
  output logic             imem_read,
  output logic             dmem_read,
  output logic             dmem_write,
  output logic             load_pc,
  output logic             load_if_id,
  output logic             load_id_ex,
  output logic             load_ex_mem,
  output logic             load_mem_wb,
  output logic             flush_if_id,
  output logic             bubble_id_ex,
  output logic             pc_redirect,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] hazard_bubbles
);

  typedef enum logic {ST_RUN, ST_WAIT} state_t;

  state_t r_state;
  logic   r_imem_done;
  logic   r_dmem_done;

  logic w_dmem_req;
  logic w_i_ok;
  logic w_d_ok;
  logic w_adv;
  logic w_hazard;

  // w_adv stays free of rst so that rst only ever acts as an asynchronous clear on the flops;
  // the externally visible outputs are masked by rst separately.
  assign w_dmem_req = ex_mem_read | ex_mem_write;
  assign w_i_ok     = r_imem_done | imem_resp;
  assign w_d_ok     = ~w_dmem_req | r_dmem_done | dmem_resp;
  assign w_adv      = w_i_ok & w_d_ok;
  assign w_hazard   = id_ex_mem_read & (id_ex_rd != 5'd0) &
                      ((if_id_use_rs1 & (if_id_rs1 == id_ex_rd)) |
                       (if_id_use_rs2 & (if_id_rs2 == id_ex_rd)));

  assign imem_read  = ~rst & ~r_imem_done;
  assign dmem_read  = ~rst & ex_mem_read  & ~r_dmem_done;
  assign dmem_write = ~rst & ex_mem_write & ~r_dmem_done;

  always_comb begin
    load_pc      = 1'b0;
    load_if_id   = 1'b0;
    load_id_ex   = 1'b0;
    load_ex_mem  = 1'b0;
    load_mem_wb  = 1'b0;
    flush_if_id  = 1'b0;
    bubble_id_ex = 1'b0;
    pc_redirect  = 1'b0;
    if (!rst && w_adv) begin
      load_id_ex  = 1'b1;
      load_ex_mem = 1'b1;
      load_mem_wb = 1'b1;
      if (br_taken) begin
        load_pc      = 1'b1;
        load_if_id   = 1'b1;
        flush_if_id  = 1'b1;
        bubble_id_ex = 1'b1;
        pc_redirect  = 1'b1;
      end else if (w_hazard) begin
        // PC and IF/ID hold so the younger instruction is re-presented after the bubble.
        bubble_id_ex = 1'b1;
      end else begin
        load_pc    = 1'b1;
        load_if_id = 1'b1;
      end
    end
  end

  // Responses landing in an advance cycle are consumed directly, so flags only latch while stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_RUN;
      r_imem_done <= 1'b0;
      r_dmem_done <= 1'b0;
    end else begin
      if (w_adv) begin
        r_imem_done <= 1'b0;
        r_dmem_done <= 1'b0;
      end else begin
        r_imem_done <= r_imem_done | imem_resp;
        r_dmem_done <= r_dmem_done | dmem_resp;
      end
      case (r_state)
        ST_RUN:  if (!w_adv) r_state <= ST_WAIT;
        ST_WAIT: if (w_adv)  r_state <= ST_RUN;
        default: r_state <= ST_RUN;
      endcase
    end
  end

`ifdef PIPE_PERF_EN
  logic [CNT_W-1:0] r_stall_cycles;
  logic [CNT_W-1:0] r_hazard_bubbles;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cycles   <= '0;
      r_hazard_bubbles <= '0;
    end else begin
      if (!w_adv)
        r_stall_cycles <= r_stall_cycles + 1'b1;
      if (w_adv && !br_taken && w_hazard)
        r_hazard_bubbles <= r_hazard_bubbles + 1'b1;
    end
  end

  assign stall_cycles   = r_stall_cycles;
  assign hazard_bubbles = r_hazard_bubbles;
`else
  assign stall_cycles   = '0;
  assign hazard_bubbles = '0;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: stalls, load-use bubble, redirect, x0 exemption, async reset.
module tb_pipeline_ctrl;
  localparam int CNT_W = 32;

  logic clk = 1'b0;
  logic rst;
  logic imem_resp, dmem_resp, ex_mem_read, ex_mem_write, id_ex_mem_read;
  logic [4:0] id_ex_rd, if_id_rs1, if_id_rs2;
  logic if_id_use_rs1, if_id_use_rs2, br_taken;
  logic imem_read, dmem_read, dmem_write;
  logic load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb;
  logic flush_if_id, bubble_id_ex, pc_redirect;
  logic [CNT_W-1:0] stall_cycles, hazard_bubbles;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pipeline_ctrl #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .imem_resp(imem_resp), .dmem_resp(dmem_resp),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .id_ex_mem_read(id_ex_mem_read), .id_ex_rd(id_ex_rd),
    .if_id_rs1(if_id_rs1), .if_id_rs2(if_id_rs2),
    .if_id_use_rs1(if_id_use_rs1), .if_id_use_rs2(if_id_use_rs2),
    .br_taken(br_taken),
    .imem_read(imem_read), .dmem_read(dmem_read), .dmem_write(dmem_write),
    .load_pc(load_pc), .load_if_id(load_if_id), .load_id_ex(load_id_ex),
    .load_ex_mem(load_ex_mem), .load_mem_wb(load_mem_wb),
    .flush_if_id(flush_if_id), .bubble_id_ex(bubble_id_ex), .pc_redirect(pc_redirect),
    .stall_cycles(stall_cycles), .hazard_bubbles(hazard_bubbles)
  );

  // {load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb, flush_if_id, bubble_id_ex, pc_redirect}
  wire [7:0] ctl = {load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb,
                    flush_if_id, bubble_id_ex, pc_redirect};
  wire [2:0] req = {imem_read, dmem_read, dmem_write};

  // Counter expectations collapse to zero when the counters are not built.
  function automatic logic [CNT_W-1:0] perf(input int n);
`ifdef PIPE_PERF_EN
    return CNT_W'(n);
`else
    return '0;
`endif
  endfunction

  task automatic chk(input string tag, input logic [CNT_W-1:0] obs, input logic [CNT_W-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
    $display("check %-12s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Apply inputs just after a falling edge; combinational outputs are sampled 1 time unit later.
  task automatic drive(input logic ir, input logic dr, input logic emr, input logic emw, input logic br);
    @(negedge clk);
    imem_resp = ir; dmem_resp = dr; ex_mem_read = emr; ex_mem_write = emw; br_taken = br;
    #1;
  endtask

  initial begin
    rst = 1'b1;
    imem_resp = 0; dmem_resp = 0; ex_mem_read = 0; ex_mem_write = 0;
    id_ex_mem_read = 0; id_ex_rd = 0; if_id_rs1 = 0; if_id_rs2 = 0;
    if_id_use_rs1 = 0; if_id_use_rs2 = 0; br_taken = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req", CNT_W'(req), 0);
    chk("rst_ctl", CNT_W'(ctl), 0);
    chk("rst_stall", stall_cycles, 0);

    // Fetch-only stall: response two cycles after release.
    @(negedge clk); rst = 1'b0;
    #1;
    chk("f0_req", CNT_W'(req), 3'b100);
    chk("f0_ctl", CNT_W'(ctl), 0);
    drive(0, 0, 0, 0, 0);
    chk("f1_ctl", CNT_W'(ctl), 0);
    drive(1, 0, 0, 0, 0);
    chk("f2_req", CNT_W'(req), 3'b100);
    chk("f2_ctl", CNT_W'(ctl), 8'b1111_1000);
    chk("f2_stall", stall_cycles, perf(2));

    // Load in MEM: imem responds at c1, dmem at c4.
    drive(0, 0, 1, 0, 0);
    chk("d0_req", CNT_W'(req), 3'b110);
    chk("d0_ctl", CNT_W'(ctl), 0);
    drive(1, 0, 1, 0, 0);
    chk("d1_req", CNT_W'(req), 3'b110);
    chk("d1_ctl", CNT_W'(ctl), 0);
    drive(0, 0, 1, 0, 0);
    chk("d2_req", CNT_W'(req), 3'b010);
    chk("d2_ctl", CNT_W'(ctl), 0);
    drive(0, 0, 1, 0, 0);
    chk("d3_req", CNT_W'(req), 3'b010);
    drive(0, 1, 1, 0, 0);
    chk("d4_req", CNT_W'(req), 3'b010);
    chk("d4_ctl", CNT_W'(ctl), 8'b1111_1000);

    // Load-use hazard on rs2, both responses together.
    id_ex_mem_read = 1; id_ex_rd = 5'd5; if_id_rs2 = 5'd5; if_id_use_rs2 = 1;
    drive(1, 1, 0, 0, 0);
    chk("hz_stall", stall_cycles, perf(6));
    chk("hz_ctl", CNT_W'(ctl), 8'b0011_1010);
    chk("hz_cnt0", hazard_bubbles, perf(0));

    // Same hazard with a redirect: redirect wins, no bubble counted.
    drive(1, 1, 0, 0, 1);
    chk("br_ctl", CNT_W'(ctl), 8'b1111_1111);
    chk("br_cnt", hazard_bubbles, perf(1));

    // Destination x0 never creates a hazard.
    id_ex_rd = 5'd0; if_id_rs1 = 5'd0; if_id_use_rs1 = 1; if_id_use_rs2 = 0;
    drive(1, 1, 0, 0, 0);
    chk("x0_ctl", CNT_W'(ctl), 8'b1111_1000);
    chk("x0_cnt", hazard_bubbles, perf(1));

    // Store pending, imem answers first: WAIT with imem_done set, then reset mid-stall.
    id_ex_mem_read = 0; if_id_use_rs1 = 0;
    drive(1, 0, 0, 1, 0);
    chk("w0_req", CNT_W'(req), 3'b101);
    chk("w0_ctl", CNT_W'(ctl), 0);
    drive(0, 0, 0, 1, 0);
    chk("w1_req", CNT_W'(req), 3'b001);
    chk("w1_stall", stall_cycles, perf(7));
    #2; rst = 1'b1; #1;
    chk("ar_req", CNT_W'(req), 0);
    chk("ar_ctl", CNT_W'(ctl), 0);
    chk("ar_stall", stall_cycles, 0);
    chk("ar_hb", hazard_bubbles, 0);
    @(negedge clk); rst = 1'b0;
    #1;
    chk("rr0_req", CNT_W'(req), 3'b101);
    chk("rr0_ctl", CNT_W'(ctl), 0);
    drive(0, 0, 0, 1, 0);
    chk("rr1_ctl", CNT_W'(ctl), 0);
    chk("rr1_stall", stall_cycles, perf(1));
    drive(1, 1, 0, 1, 0);
    chk("rr2_ctl", CNT_W'(ctl), 8'b1111_1000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
